// File: rtl/lsu.sv
// RV32I load/store unit: one request/acknowledge memory transaction per op, with
// store byte steering and load extraction. Optional `MISALIGN_TRAP_EN rejects misaligned accesses.
module lsu (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    input  logic        req_store_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        store_q, store_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        illegal;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [31:0] ld_data;

    function automatic logic [31:0] ld_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'b00:   return {{24{b[7] & ~f3[2]}}, b};
            2'b01:   return {{16{h[15] & ~f3[2]}}, h};
            default: return w;
        endcase
    endfunction

    always_comb begin
        illegal = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11) ||
                  (req_store_i && req_funct3_i[2]);
`ifdef MISALIGN_TRAP_EN
        if (req_funct3_i[1:0] == 2'b01 && req_addr_i[0])
            illegal = 1'b1;
        if (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00)
            illegal = 1'b1;
`endif
    end

    // Replicate store data across lanes so the strobe alone selects the target bytes.
    always_comb begin
        case (req_funct3_i[1:0])
            2'b00: begin
                st_data = {4{req_wdata_i[7:0]}};
                st_strb = 4'b0001 << req_addr_i[1:0];
            end
            2'b01: begin
                st_data = {2{req_wdata_i[15:0]}};
                st_strb = req_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = req_wdata_i;
                st_strb = 4'b1111;
            end
        endcase
    end

    assign ld_data = ld_fmt(f3_q, off_q, mem_rdata_i);

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        f3_d         = f3_q;
        off_d        = off_q;
        store_d      = store_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (illegal) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_store_i;
                        mem_addr_d  = {req_addr_i[31:2], 2'b00};
                        mem_wdata_d = req_store_i ? st_data : 32'h0;
                        mem_wstrb_d = req_store_i ? st_strb : 4'b0000;
                        f3_d        = req_funct3_i;
                        off_d       = req_addr_i[1:0];
                        store_d     = req_store_i;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack_i) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_wstrb_d  = 4'b0000;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = store_q ? 32'h0 : ld_data;
                end
            end
            RESP: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'h0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_wstrb_q  <= 4'b0000;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            store_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            store_q      <= store_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE) && rst_n_i;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_wstrb_o  = mem_wstrb_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: expected responses are queued at request time and
// checked by a monitor when resp_valid fires.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_store;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb_q[$];
    int tests = 0;
    int fails = 0;
    int resp_cnt = 0;

    lsu dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_funct3_i(req_funct3), .req_store_i(req_store),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            resp_t e;
            resp_cnt++;
            if (sb_q.size() == 0) begin
                check("resp_unexpected", {31'h0, resp_valid}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !req_ready; i++) step();
        check("req_ready_wait", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic do_op(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3, input logic st, input logic [31:0] rd,
                         input int dly, input logic err, input logic [31:0] exp_rd,
                         input logic [31:0] exp_maddr, input logic [31:0] exp_wdata,
                         input logic [3:0] exp_strb);
        resp_t e;
        wait_ready();
        req_valid = 1'b1; req_addr = addr; req_wdata = wd; req_funct3 = f3; req_store = st;
        e.rdata = err ? 32'h0 : exp_rd;
        e.err   = err;
        sb_q.push_back(e);
        step();
        req_valid = 1'b0;
        if (err) begin
            check({tag, "_err_noreq"}, {31'h0, mem_req}, 32'h0);
            check({tag, "_err_valid_c1"}, {31'h0, resp_valid}, 32'h1);
            step();
            check({tag, "_err_ready_c2"}, {31'h0, req_ready}, 32'h1);
            return;
        end
        for (int c = 0; c <= dly; c++) begin
            check({tag, "_mem_req"}, {31'h0, mem_req}, 32'h1);
            check({tag, "_mem_addr"}, mem_addr, exp_maddr);
            check({tag, "_mem_we"}, {31'h0, mem_we}, {31'h0, st});
            check({tag, "_mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, exp_strb});
            check({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
            check({tag, "_no_early_resp"}, {31'h0, resp_valid}, 32'h0);
            if (c == dly) begin
                mem_ack = 1'b1; mem_rdata = rd;
            end
            step();
        end
        mem_ack = 1'b0; mem_rdata = 32'hA5A5_5A5A;
        check({tag, "_resp_c2"}, {31'h0, resp_valid}, 32'h1);
        check({tag, "_req_drop"}, {31'h0, mem_req}, 32'h0);
        step();
        check({tag, "_resp_pulse"}, {31'h0, resp_valid}, 32'h0);
        check({tag, "_ready_c3"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        int rc;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        req_funct3 = '0; req_store = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst_resp", {resp_rdata[30:0], resp_valid | resp_err}, 32'h0);
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("ready_after_rst", {31'h0, req_ready}, 32'h1);

        // Stray ack while idle must not start anything.
        mem_ack = 1'b1;
        step(); step();
        mem_ack = 1'b0;
        check("idle_ack_noreq", {31'h0, mem_req}, 32'h0);
        check("idle_ack_noresp", resp_cnt, 0);

        do_op("lw",  32'h100, 32'h0, 3'b010, 1'b0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF,
              32'h100, 32'h0, 4'b0000);
        do_op("lb",  32'h203, 32'h0, 3'b000, 1'b0, 32'h80112233, 0, 1'b0, 32'hFFFFFF80,
              32'h200, 32'h0, 4'b0000);
        do_op("lbu", 32'h203, 32'h0, 3'b100, 1'b0, 32'h80112233, 0, 1'b0, 32'h00000080,
              32'h200, 32'h0, 4'b0000);
        do_op("sh",  32'h302, 32'h0000ABCD, 3'b001, 1'b1, 32'hFFFFFFFF, 0, 1'b0, 32'h0,
              32'h300, 32'hABCDABCD, 4'b1100);
        do_op("lhu", 32'h40, 32'h0, 3'b101, 1'b0, 32'h1234F00D, 3, 1'b0, 32'h0000F00D,
              32'h40, 32'h0, 4'b0000);
        do_op("sb",  32'h601, 32'h000000A5, 3'b000, 1'b1, 32'h12345678, 1, 1'b0, 32'h0,
              32'h600, 32'hA5A5A5A5, 4'b0010);
        do_op("lh",  32'h702, 32'h0, 3'b001, 1'b0, 32'h8001_7FFF, 0, 1'b0, 32'hFFFF8001,
              32'h700, 32'h0, 4'b0000);
`ifdef MISALIGN_TRAP_EN
        do_op("sw_mis", 32'h5, 32'h11223344, 3'b010, 1'b1, 32'h0, 0, 1'b1, 32'h0,
              32'h0, 32'h0, 4'b0000);
        do_op("lh_mis", 32'h703, 32'h0, 3'b001, 1'b0, 32'h0, 0, 1'b1, 32'h0,
              32'h0, 32'h0, 4'b0000);
`else
        do_op("sw_mis", 32'h5, 32'h11223344, 3'b010, 1'b1, 32'h0, 0, 1'b0, 32'h0,
              32'h4, 32'h11223344, 4'b1111);
        do_op("lh_mis", 32'h703, 32'h0, 3'b001, 1'b0, 32'h8001_7FFF, 0, 1'b0, 32'hFFFF8001,
              32'h700, 32'h0, 4'b0000);
`endif
        do_op("f3_111", 32'h100, 32'h0, 3'b111, 1'b0, 32'h0, 0, 1'b1, 32'h0,
              32'h0, 32'h0, 4'b0000);
        do_op("st_f3_4", 32'h100, 32'h0, 3'b100, 1'b1, 32'h0, 0, 1'b1, 32'h0,
              32'h0, 32'h0, 4'b0000);

        // Reset in the middle of an access: no response, late ack ignored.
        wait_ready();
        rc = resp_cnt;
        req_valid = 1'b1; req_addr = 32'h80; req_funct3 = 3'b010; req_store = 1'b0;
        step();
        req_valid = 1'b0;
        check("rst_mid_req_before", {31'h0, mem_req}, 32'h1);
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_req_drop", {31'h0, mem_req}, 32'h0);
        step();
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        step(); step();
        mem_ack = 1'b0;
        check("rst_mid_noreq", {31'h0, mem_req}, 32'h0);
        check("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        step();
        check("rst_mid_noresp", resp_cnt, rc);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit in the execute/memory boundary of the RV32I core, directly downstream of the ALU. It takes the ALU's effective address (rs1 + imm) plus store data and funct3, and runs one data-memory transaction per request over a request/acknowledge bus. It steers and masks store bytes, and extracts and sign- or zero-extends load data. It returns a one-cycle response to the pipeline.

## Interface
- Parameters: none; data and address width fixed at 32.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents a memory op.
- req_ready  out  1  LSU accepts a request; 1 only in IDLE with rst_n high.
- req_addr  in  32  effective address from the ALU.
- req_wdata  in  32  store data (rs2).
- req_funct3  in  3  RISC-V funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
- req_store  in  1  1 = store, 0 = load.
- mem_req  out  1  memory transaction active.
- mem_we  out  1  write enable.
- mem_addr  out  32  word address, bits [1:0] always 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte strobes; 0000 on loads.
- mem_rdata  in  32  read word, valid with mem_ack.
- mem_ack  in  1  transaction complete; sampled only while mem_req=1.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected; no memory access made.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE → ACCESS: on a clock edge with req_valid & req_ready and a legal request. Address, data, funct3 and store are latched at that edge.
- IDLE → RESP with resp_err=1: on an illegal request, with no memory access. Illegal means funct3 011/110/111, store with funct3[2]=1, or misaligned when the macro is enabled.
- ACCESS: mem_req=1. mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_ack is sampled high. On that edge the formatted load data is latched and the FSM goes to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Store steering by off = addr[1:0]:
  - SB: byte replicated to all 4 lanes, wstrb = 0001 << off.
  - SH: halfword replicated to both halves, wstrb = 0011 << (2*addr[1]).
  - SW: wstrb = 1111.
- Load extraction:
  - LB/LBU: lane off.
  - LH/LHU: half addr[1].
  - LW: full word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- mem_ack outside ACCESS is ignored. mem_rdata is ignored for stores.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0, state IDLE. All memory-side and response outputs are registered.
- Minimum latency, with accept at edge of cycle 0:
  - Cycle 1: mem_req=1.
  - Cycle 1: mem_ack=1 completes the access.
  - Cycle 2: resp_valid=1.
  - Cycle 3: req_ready=1.
- Each wait cycle (mem_ack=0 in ACCESS) adds one cycle. There is no timeout.
- Error path: accept in cycle 0, resp_valid=1 with resp_err=1 in cycle 1, req_ready=1 in cycle 2.
- req_valid while req_ready=0 has no effect. The upstream stage holds the request until accepted.
- Reset asserted mid-ACCESS: mem_req drops asynchronously and the operation is discarded with no response. A mem_ack arriving after reset release is ignored.

## Configuration
- MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1 are illegal, returning resp_err=1 with no access.
  - LW/SW with addr[1:0]≠00 are illegal, returning resp_err=1 with no access.
- MISALIGN_TRAP_EN undefined:
  - No alignment check. Halfword ops ignore addr[0]; word ops ignore addr[1:0].
  - resp_err is asserted only for illegal funct3.

## Test plan
- LW at 0x100, mem_rdata=0xDEADBEEF, mem_ack in first cycle → mem_addr=0x100, mem_wstrb=0000, resp_valid in cycle 2 with resp_rdata=0xDEADBEEF, resp_err=0.
- LB and LBU at 0x203, mem_rdata=0x80112233 → resp_rdata=0xFFFFFF80 for LB, 0x00000080 for LBU, mem_addr=0x200.
- SH at 0x302, wdata=0x0000ABCD → mem_we=1, mem_wdata=0xABCDABCD, mem_wstrb=1100, resp_rdata=0.
- LHU at 0x40, mem_ack delayed 3 cycles, mem_rdata=0x1234F00D → mem_addr/mem_we/mem_wstrb stable all 4 ACCESS cycles, resp_valid exactly one cycle, resp_rdata=0x0000F00D.
- SW at 0x5, with MISALIGN_TRAP_EN defined → mem_req never asserts, resp_err=1 in cycle 1. Without the macro → mem_addr=0x4, mem_wstrb=1111. Funct3=111 → resp_err=1 in both builds.
- rst_n low during ACCESS → mem_req=0 immediately, no resp_valid. After release, a late mem_ack is ignored and req_ready=1.
